display_decoder: RTL and testbench

- Registered 5-bit code to 7-segment decoder: inputs c1..c5 (c1 = MSB) select one of 32 glyphs, decoded into segments a..g.
- Sits between control logic and a single 7-segment digit.
- Glyph set: 0-9, A-F, a fixed letter/symbol set for codes 16-30, blank for code 31.

---
 rtl/display_pkg.sv | 48 ++++
 rtl/display_seg_lut.sv | 50 +++++
 rtl/display_decoder.sv | 56 +++++
 tb/tb_display_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph constants for the 7-segment display decoder.
// Segment bit order throughout: [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
// All patterns are active-high (1 = segment lit).
package display_pkg;

    localparam int SEG_W  = 7;
    localparam int CODE_W = 5;

    typedef logic [SEG_W-1:0]  seg_t;
    typedef logic [CODE_W-1:0] code_t;

    // Hex digits
    localparam seg_t SEG_0          = 7'b1111110;
    localparam seg_t SEG_1          = 7'b0110000;
    localparam seg_t SEG_2          = 7'b1101101;
    localparam seg_t SEG_3          = 7'b1111001;
    localparam seg_t SEG_4          = 7'b0110011;
    localparam seg_t SEG_5          = 7'b1011011;
    localparam seg_t SEG_6          = 7'b1011111;
    localparam seg_t SEG_7          = 7'b1110000;
    localparam seg_t SEG_8          = 7'b1111111;
    localparam seg_t SEG_9          = 7'b1111011;
    localparam seg_t SEG_A          = 7'b1110111;
    localparam seg_t SEG_B          = 7'b0011111;
    localparam seg_t SEG_C          = 7'b1001110;
    localparam seg_t SEG_D          = 7'b0111101;
    localparam seg_t SEG_E          = 7'b1001111;
    localparam seg_t SEG_F          = 7'b1000111;

    // Extended letters and symbols
    localparam seg_t SEG_G          = 7'b1011110;
    localparam seg_t SEG_H          = 7'b0110111;
    localparam seg_t SEG_J          = 7'b0111000;
    localparam seg_t SEG_L          = 7'b0001110;
    localparam seg_t SEG_N          = 7'b0010101;
    localparam seg_t SEG_O          = 7'b0011101;
    localparam seg_t SEG_P          = 7'b1100111;
    localparam seg_t SEG_Q          = 7'b1110011;
    localparam seg_t SEG_R          = 7'b0000101;
    localparam seg_t SEG_T          = 7'b0001111;
    localparam seg_t SEG_U          = 7'b0111110;
    localparam seg_t SEG_U_SMALL    = 7'b0011100;
    localparam seg_t SEG_Y          = 7'b0111011;
    localparam seg_t SEG_DASH       = 7'b0000001;
    localparam seg_t SEG_UNDERSCORE = 7'b0001000;
    localparam seg_t SEG_BLANK      = 7'b0000000;

endpackage

// File: rtl/display_seg_lut.sv
// Combinational glyph lookup: 5-bit code to active-high segment pattern.
module display_seg_lut
    import display_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    // Map each of the 32 codes to its glyph.
    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        seg_o = SEG_BLANK;
        case (code_i)
            5'd0:  seg_o = SEG_0;
            5'd1:  seg_o = SEG_1;
            5'd2:  seg_o = SEG_2;
            5'd3:  seg_o = SEG_3;
            5'd4:  seg_o = SEG_4;
            5'd5:  seg_o = SEG_5;
            5'd6:  seg_o = SEG_6;
            5'd7:  seg_o = SEG_7;
            5'd8:  seg_o = SEG_8;
            5'd9:  seg_o = SEG_9;
            5'd10: seg_o = SEG_A;
            5'd11: seg_o = SEG_B;
            5'd12: seg_o = SEG_C;
            5'd13: seg_o = SEG_D;
            5'd14: seg_o = SEG_E;
            5'd15: seg_o = SEG_F;
            5'd16: seg_o = SEG_G;
            5'd17: seg_o = SEG_H;
            5'd18: seg_o = SEG_J;
            5'd19: seg_o = SEG_L;
            5'd20: seg_o = SEG_N;
            5'd21: seg_o = SEG_O;
            5'd22: seg_o = SEG_P;
            5'd23: seg_o = SEG_Q;
            5'd24: seg_o = SEG_R;
            5'd25: seg_o = SEG_T;
            5'd26: seg_o = SEG_U;
            5'd27: seg_o = SEG_U_SMALL;
            5'd28: seg_o = SEG_Y;
            5'd29: seg_o = SEG_DASH;
            5'd30: seg_o = SEG_UNDERSCORE;
            5'd31: seg_o = SEG_BLANK;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_decoder.sv
// Registered 5-bit code to 7-segment decoder for a single digit.
// Polarity is applied before the register, so the register holds pin levels.
module display_decoder
    import display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic c1,
    input  logic c2,
    input  logic c3,
    input  logic c4,
    input  logic c5,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);

    // Blank digit expressed as physical pin levels.
    localparam seg_t BLANK_LEVEL = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [4:0] code;
    seg_t       lut_seg;
    seg_t       seg_d;
    seg_t       seg_q;

    assign code = {c1, c2, c3, c4, c5};

    display_seg_lut u_lut (
        .code_i (code),
        .seg_o  (lut_seg)
    );

    // Convert the active-high glyph to pin polarity.
    always_comb begin
        seg_d = ACTIVE_LOW ? ~lut_seg : lut_seg;
    end

    // Output register; reset loads a blank digit and overrides the code.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            seg_q <= BLANK_LEVEL;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_display_decoder.sv
// Self-checking bench for display_decoder: both polarities driven in parallel,
// expected patterns built from a per-glyph list of lit segment letters.
module tb_display_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, c4 = 1'b0, c5 = 1'b0;

    logic a0, b0, cc0, d0, e0, f0, g0;
    logic a1, b1, cc1, d1, e1, f1, g1;
    logic [6:0] obs_hi, obs_lo;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] exp_hi;   // model of the active-high register contents

    // Lit segments of each glyph, by letter, code 0..31.
    string glyph_str [32] = '{
        "abcdef", "bc",    "abdeg",  "abcdg",  "bcfg",  "acdfg",  "acdefg", "abc",
        "abcdefg","abcdfg","abcefg", "cdefg",  "adef",  "bcdeg",  "adefg",  "aefg",
        "acdef",  "bcefg", "bcd",    "def",    "ceg",   "cdeg",   "abefg",  "abcfg",
        "eg",     "defg",  "bcdef",  "cde",    "bcdfg", "g",      "d",      ""
    };

    always #5 clk = ~clk;

    display_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk (clk), .rst (rst),
        .c1 (c1), .c2 (c2), .c3 (c3), .c4 (c4), .c5 (c5),
        .a (a0), .b (b0), .c (cc0), .d (d0), .e (e0), .f (f0), .g (g0)
    );

    display_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk (clk), .rst (rst),
        .c1 (c1), .c2 (c2), .c3 (c3), .c4 (c4), .c5 (c5),
        .a (a1), .b (b1), .c (cc1), .d (d1), .e (e1), .f (f1), .g (g1)
    );

    assign obs_hi = {a0, b0, cc0, d0, e0, f0, g0};
    assign obs_lo = {a1, b1, cc1, d1, e1, f1, g1};

    // Build the abcdefg pattern from the glyph's letter list.
    function automatic logic [6:0] glyph(input int code);
        logic [6:0] r;
        string      s;
        int         idx;
        r = '0;
        s = glyph_str[code];
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - int'("a");
            r[6 - idx] = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_code(input int code);
        logic [4:0] v;
        v = code[4:0];
        {c1, c2, c3, c4, c5} = v;
    endtask

    // Apply inputs, take one edge, update the model and check both polarities.
    task automatic tick(input logic r, input int code, input string tag);
        rst = r;
        set_code(code);
        @(posedge clk);
        #1;
        exp_hi = r ? 7'b0000000 : glyph(code);
        check(tag, obs_hi, exp_hi);
        check({tag, "_al"}, obs_lo, ~exp_hi);
    endtask

    initial begin
        logic [6:0] held;
        logic       r;
        int         code;

        // Reset with code 8 presented for two edges.
        tick(1'b1, 8, "reset0");
        tick(1'b1, 8, "reset1");
        check("reset_blank_hi", obs_hi, 7'b0000000);
        check("reset_blank_lo", obs_lo, 7'b1111111);

        // Latency: previous value held before the edge, q after it.
        tick(1'b0, 0, "pre_latency");
        held = obs_hi;
        set_code(23);
        #2;
        check("hold_before_edge", obs_hi, held);
        tick(1'b0, 23, "latency_q");
        check("latency_q_lit", obs_hi, 7'b1110011);

        // Full sweep in both polarities.
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, i, $sformatf("sweep_%0d", i));
            if (i == 0)  check("spot_0",  obs_hi, 7'b1111110);
            if (i == 1)  check("spot_1_al", obs_lo, 7'b1001111);
            if (i == 18) check("spot_18", obs_hi, 7'b0111000);
            if (i == 31) check("spot_31", obs_hi, 7'b0000000);
        end

        // Back-to-back alternation 8/31.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, (i % 2 == 0) ? 8 : 31, $sformatf("alt_%0d", i));
            check($sformatf("alt_lit_%0d", i), obs_hi,
                  (i % 2 == 0) ? 7'b1111111 : 7'b0000000);
        end

        // Mid-cycle glitch with no edge leaves the output alone.
        tick(1'b0, 5, "glitch_base");
        held = obs_hi;
        set_code(8);
        #1;
        set_code(31);
        #1;
        check("glitch_hold", obs_hi, held);
        tick(1'b0, 5, "glitch_after");

        // Reset in the middle of operation, then recovery.
        tick(1'b0, 8, "mid_pre");
        check("mid_pre_lit", obs_hi, 7'b1111111);
        tick(1'b1, 8, "mid_reset");
        check("mid_reset_blank", obs_hi, 7'b0000000);
        tick(1'b0, 8, "mid_release");
        check("mid_release_lit", obs_hi, 7'b1111111);

        // Random codes with occasional reset.
        for (int i = 0; i < 60; i++) begin
            code = int'($urandom_range(0, 31));
            r = ($urandom_range(0, 9) == 0);
            tick(r, code, $sformatf("rand_%0d_c%0d_r%0d", i, code, r));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
